// File: rtl/axi_rr_arbiter_pkg.sv
// axi_rr_arbiter_pkg
//   Shared definitions for the two-master AXI4-Lite round-robin arbiter:
//   arbiter state encoding, default bus widths, AXI response codes and the
//   grant identifier used by the last_grant register.
package axi_rr_arbiter_pkg;

  // IDLE: no transaction; RD0/RD1: read owned by m0/m1; WR: write owned by m1.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    WR   = 2'd3
  } arb_state_t;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_RESP_W = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Value of last_grant when m1 was the most recent winner.
  localparam logic GNT_M1 = 1'b1;

endpackage

// File: rtl/axi_rr_arbiter_rr_arb2.sv
// rr_arb2
//   Two-requester round-robin grant logic, purely combinational.
//   Ports:
//     req0, req1  : request lines of requester 0 / 1
//     last_grant  : requester that won the previous arbitration (1 = req1)
//     gnt0, gnt1  : one-hot (or zero) grant
module rr_arb2
  import axi_rr_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt0,
  output logic gnt1
);

  logic m1_was_last;

  assign m1_was_last = (last_grant == GNT_M1);

  // A lone requester always wins; on a tie the one that did not win last
  // time takes the grant.
  assign gnt0 = req0 & (~req1 | m1_was_last);
  assign gnt1 = req1 & (~req0 | ~m1_was_last);

endmodule

// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter
//   Two-master to one-slave AXI4-Lite arbiter. m0 (IFU) issues reads only,
//   m1 (LSU) issues reads and writes. One transaction is outstanding at a
//   time and masters are served round-robin. Data/response fields pass
//   through; only valid/ready are gated by the current grant.
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     m0_ar*/m0_r*          : master 0 read address / read data channels
//     m1_ar*/m1_r*          : master 1 read address / read data channels
//     m1_aw*/m1_w*/m1_b*    : master 1 write address / data / response
//     s_ar*/s_r*/s_aw*/s_w*/s_b* : slave-side AXI4-Lite channels
module axi_rr_arbiter
  import axi_rr_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = AXI_ADDR_W,
  parameter int unsigned DATA_W = AXI_DATA_W,
  parameter int unsigned STRB_W = DATA_W / 8,
  parameter int unsigned RESP_W = AXI_RESP_W
) (
  input  logic              clk,
  input  logic              rst,
  // m0 AR / R
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [RESP_W-1:0] m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  // m1 AR / R
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [RESP_W-1:0] m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  // m1 AW / W / B
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  output logic [RESP_W-1:0] m1_bresp,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  // slave AR / R
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [RESP_W-1:0] s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready,
  // slave AW / W / B
  output logic [ADDR_W-1:0] s_awaddr,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  output logic              s_wvalid,
  input  logic              s_wready,
  input  logic [RESP_W-1:0] s_bresp,
  input  logic              s_bvalid,
  output logic              s_bready
);

  arb_state_t state_q, state_d;
  logic       ar_done_q, aw_done_q, w_done_q;
  logic       last_grant_q;

  logic req0, req1, m1_wr_req;
  logic gnt0, gnt1;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic wr_resp_phase;

  assign req0      = m0_arvalid;
  assign m1_wr_req = m1_awvalid | m1_wvalid;
  assign req1      = m1_wr_req | m1_arvalid;

  rr_arb2 u_rr_arb2 (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  // Handshakes are observed on the slave side, where the gated valid/ready
  // pair already reflects the grant and the per-transaction flags.
  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid  & s_rready;
  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid  & s_wready;
  assign b_hs  = s_bvalid  & s_bready;

  assign wr_resp_phase = aw_done_q & w_done_q;

  // State register, grant history and per-transaction flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_M1;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (gnt0 | gnt1)) begin
        last_grant_q <= gnt1;
      end
    end
  end

  // Flags start clean in every state, so they are cleared on any transition.
  always_ff @(posedge clk) begin
    if (rst || (state_d != state_q)) begin
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (ar_hs) ar_done_q <= 1'b1;
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt0) begin
          state_d = RD0;
        end else if (gnt1) begin
          state_d = m1_wr_req ? WR : RD1;
        end
      end
      RD0, RD1: begin
        if (r_hs) state_d = IDLE;
      end
      WR: begin
        if (b_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode. Everything defaults to zero, which covers IDLE, the
  // non-granted master and the reset cycles.
  always_comb begin
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = '0;
    m1_bvalid  = 1'b0;
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    if (!rst) begin
      case (state_q)
        RD0: begin
          s_araddr   = m0_araddr;
          s_arvalid  = m0_arvalid & ~ar_done_q;
          m0_arready = s_arready  & ~ar_done_q;
          s_rready   = m0_rready  & ar_done_q;
          m0_rvalid  = s_rvalid   & ar_done_q;
          m0_rdata   = s_rdata;
          m0_rresp   = s_rresp;
        end
        RD1: begin
          s_araddr   = m1_araddr;
          s_arvalid  = m1_arvalid & ~ar_done_q;
          m1_arready = s_arready  & ~ar_done_q;
          s_rready   = m1_rready  & ar_done_q;
          m1_rvalid  = s_rvalid   & ar_done_q;
          m1_rdata   = s_rdata;
          m1_rresp   = s_rresp;
        end
        WR: begin
          // AW and W run independently; B opens only after both are done.
          s_awaddr   = m1_awaddr;
          s_awvalid  = m1_awvalid & ~aw_done_q;
          m1_awready = s_awready  & ~aw_done_q;
          s_wdata    = m1_wdata;
          s_wstrb    = m1_wstrb;
          s_wvalid   = m1_wvalid  & ~w_done_q;
          m1_wready  = s_wready   & ~w_done_q;
          s_bready   = m1_bready  & wr_resp_phase;
          m1_bvalid  = s_bvalid   & wr_resp_phase;
          m1_bresp   = s_bresp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
module tb_axi_rr_arbiter;
  import axi_rr_arbiter_pkg::*;

  logic        clk, rst;
  logic [31:0] m0_araddr;  logic m0_arvalid, m0_arready;
  logic [63:0] m0_rdata;   logic [1:0] m0_rresp; logic m0_rvalid, m0_rready;
  logic [31:0] m1_araddr;  logic m1_arvalid, m1_arready;
  logic [63:0] m1_rdata;   logic [1:0] m1_rresp; logic m1_rvalid, m1_rready;
  logic [31:0] m1_awaddr;  logic m1_awvalid, m1_awready;
  logic [63:0] m1_wdata;   logic [7:0] m1_wstrb; logic m1_wvalid, m1_wready;
  logic [1:0]  m1_bresp;   logic m1_bvalid, m1_bready;
  logic [31:0] s_araddr;   logic s_arvalid, s_arready;
  logic [63:0] s_rdata;    logic [1:0] s_rresp; logic s_rvalid, s_rready;
  logic [31:0] s_awaddr;   logic s_awvalid, s_awready;
  logic [63:0] s_wdata;    logic [7:0] s_wstrb; logic s_wvalid, s_wready;
  logic [1:0]  s_bresp;    logic s_bvalid, s_bready;

  int checks = 0;
  int errors = 0;

  axi_rr_arbiter #(.ADDR_W(32), .DATA_W(64), .STRB_W(8), .RESP_W(2)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 none, 1 read for m0, 2 read for m1, 3 write for m1.
  // a_acc: address phase accepted; w_acc: write data accepted.
  int unsigned owner;
  bit a_acc, w_acc, prev_winner;

  logic [31:0] e_s_araddr, e_s_awaddr;
  logic        e_s_arvalid, e_s_rready, e_s_awvalid, e_s_wvalid, e_s_bready;
  logic [63:0] e_s_wdata, e_m0_rdata, e_m1_rdata;
  logic [7:0]  e_s_wstrb;
  logic        e_m0_arready, e_m0_rvalid, e_m1_arready, e_m1_rvalid;
  logic [1:0]  e_m0_rresp, e_m1_rresp, e_m1_bresp;
  logic        e_m1_awready, e_m1_wready, e_m1_bvalid;

  always @(posedge clk) begin
    bit r0, r1, who;
    if (rst) begin
      owner = 0; a_acc = 0; w_acc = 0; prev_winner = 1;
    end else begin
      case (owner)
        0: begin
          r0 = m0_arvalid;
          r1 = m1_awvalid | m1_wvalid | m1_arvalid;
          if (r0 || r1) begin
            if (r0 && r1) who = ~prev_winner;
            else          who = r1;
            prev_winner = who;
            if (!who) owner = 1;
            else      owner = (m1_awvalid || m1_wvalid) ? 3 : 2;
            a_acc = 0; w_acc = 0;
          end
        end
        1, 2: begin
          if (e_s_rready && s_rvalid) begin
            owner = 0; a_acc = 0;
          end else if (e_s_arvalid && s_arready) begin
            a_acc = 1;
          end
        end
        default: begin
          if (e_s_bready && s_bvalid) begin
            owner = 0; a_acc = 0; w_acc = 0;
          end else begin
            if (e_s_awvalid && s_awready) a_acc = 1;
            if (e_s_wvalid && s_wready)   w_acc = 1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    bit g1;
    e_s_araddr = '0; e_s_arvalid = 0; e_s_rready = 0;
    e_s_awaddr = '0; e_s_awvalid = 0; e_s_wdata = '0; e_s_wstrb = '0; e_s_wvalid = 0; e_s_bready = 0;
    e_m0_arready = 0; e_m0_rdata = '0; e_m0_rresp = '0; e_m0_rvalid = 0;
    e_m1_arready = 0; e_m1_rdata = '0; e_m1_rresp = '0; e_m1_rvalid = 0;
    e_m1_awready = 0; e_m1_wready = 0; e_m1_bresp = '0; e_m1_bvalid = 0;
    if (!rst) begin
      if (owner == 1 || owner == 2) begin
        g1 = (owner == 2);
        e_s_araddr  = g1 ? m1_araddr : m0_araddr;
        e_s_arvalid = (g1 ? m1_arvalid : m0_arvalid) && !a_acc;
        e_s_rready  = (g1 ? m1_rready : m0_rready) && a_acc;
        if (g1) begin
          e_m1_arready = s_arready && !a_acc; e_m1_rvalid = s_rvalid && a_acc;
          e_m1_rdata = s_rdata; e_m1_rresp = s_rresp;
        end else begin
          e_m0_arready = s_arready && !a_acc; e_m0_rvalid = s_rvalid && a_acc;
          e_m0_rdata = s_rdata; e_m0_rresp = s_rresp;
        end
      end else if (owner == 3) begin
        e_s_awaddr = m1_awaddr; e_s_awvalid = m1_awvalid && !a_acc; e_m1_awready = s_awready && !a_acc;
        e_s_wdata = m1_wdata; e_s_wstrb = m1_wstrb;
        e_s_wvalid = m1_wvalid && !w_acc; e_m1_wready = s_wready && !w_acc;
        e_s_bready = m1_bready && a_acc && w_acc;
        e_m1_bvalid = s_bvalid && a_acc && w_acc;
        e_m1_bresp = s_bresp;
      end
    end
    chk("model_s_ar", {s_araddr, s_arvalid}, {e_s_araddr, e_s_arvalid});
    chk("model_s_rready", s_rready, e_s_rready);
    chk("model_s_aw", {s_awaddr, s_awvalid}, {e_s_awaddr, e_s_awvalid});
    chk("model_s_w", {s_wdata, s_wstrb, s_wvalid}, {e_s_wdata, e_s_wstrb, e_s_wvalid});
    chk("model_s_bready", s_bready, e_s_bready);
    chk("model_m0", {m0_arready, m0_rdata, m0_rresp, m0_rvalid},
        {e_m0_arready, e_m0_rdata, e_m0_rresp, e_m0_rvalid});
    chk("model_m1_rd", {m1_arready, m1_rdata, m1_rresp, m1_rvalid},
        {e_m1_arready, e_m1_rdata, e_m1_rresp, e_m1_rvalid});
    chk("model_m1_wr", {m1_awready, m1_wready, m1_bresp, m1_bvalid},
        {e_m1_awready, e_m1_wready, e_m1_bresp, e_m1_bvalid});
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic any_out();
    return |{m0_arready, m0_rdata, m0_rresp, m0_rvalid, m1_arready, m1_rdata, m1_rresp,
             m1_rvalid, m1_awready, m1_wready, m1_bresp, m1_bvalid, s_araddr, s_arvalid,
             s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_arvalid(input string nm);
    int n = 0;
    @(negedge clk);
    while (!s_arvalid && n < 40) begin @(negedge clk); n++; end
    chk(nm, s_arvalid, 1'b1);
  endtask

  task automatic wait_rready(input string nm);
    int n = 0;
    @(negedge clk);
    while (!s_rready && n < 40) begin @(negedge clk); n++; end
    chk(nm, s_rready, 1'b1);
  endtask

  // Serve one read: check the granted address, accept AR after ar_lat extra
  // cycles, return data r_lat cycles later and check the pass-through.
  task automatic do_read(input bit who, input logic [31:0] addr, input int ar_lat,
                         input int r_lat, input logic [63:0] data, input logic [1:0] resp);
    wait_arvalid("ar_timeout");
    chk("grant_addr", s_araddr, addr);
    step();
    repeat (ar_lat) step();
    s_arready = 1;
    step();
    s_arready = 0;
    if (who) m1_arvalid = 0; else m0_arvalid = 0;
    repeat (r_lat) step();
    s_rvalid = 1; s_rdata = data; s_rresp = resp;
    wait_rready("r_timeout");
    chk("rvalid_owner", who ? m1_rvalid : m0_rvalid, 1'b1);
    chk("rvalid_other", who ? m0_rvalid : m1_rvalid, 1'b0);
    chk("rdata_pass", who ? m1_rdata : m0_rdata, data);
    chk("rresp_pass", who ? m1_rresp : m0_rresp, resp);
    step();
    s_rvalid = 0; s_rdata = '0; s_rresp = '0;
    @(negedge clk);
    chk("rvalid_one_cycle", who ? m1_rvalid : m0_rvalid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1;
    m0_araddr = 32'h8000_0000; m0_arvalid = 1; m0_rready = 1;
    m1_araddr = 32'h1000_0020; m1_arvalid = 1; m1_rready = 1;
    m1_awaddr = 32'h1000_0100; m1_awvalid = 1; m1_wdata = 64'h55; m1_wstrb = 8'hff;
    m1_wvalid = 1; m1_bready = 1;
    s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
    s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;

    // Reset held with every master requesting: all outputs quiet.
    repeat (3) begin
      @(negedge clk);
      chk("rst_quiet", any_out(), 1'b0);
      step();
    end
    rst = 0; m1_awvalid = 0; m1_wvalid = 0;
    @(negedge clk);
    chk("idle_no_fwd", s_arvalid, 1'b0);

    // Simultaneous reads after reset: m0 first, then m1.
    do_read(1'b0, 32'h8000_0000, 1, 2, 64'h0000_0000_0000_1234, RESP_OKAY);
    do_read(1'b1, 32'h1000_0020, 0, 0, 64'hdead_beef_0000_0001, RESP_SLVERR);

    // m0 alone, then both again: m1 must win this tie.
    step();
    m0_araddr = 32'h8000_0008; m0_arvalid = 1;
    do_read(1'b0, 32'h8000_0008, 0, 1, 64'h0123_4567_89ab_cdef, RESP_OKAY);
    step();
    m0_araddr = 32'h8000_0010; m0_arvalid = 1;
    m1_araddr = 32'h1000_0030; m1_arvalid = 1;
    do_read(1'b1, 32'h1000_0030, 0, 0, 64'h1111_2222_3333_4444, RESP_OKAY);
    do_read(1'b0, 32'h8000_0010, 0, 0, 64'h5555_6666_7777_8888, RESP_OKAY);

    // Write: W two cycles ahead of AW, m0 arrives mid-write, bready stalled.
    step();
    m1_wvalid = 1; m1_wdata = 64'h41; m1_wstrb = 8'h01; s_wready = 1; s_awready = 1;
    @(negedge clk);
    chk("wr_idle_no_fwd", s_wvalid, 1'b0);
    step();
    m0_araddr = 32'h8000_0100; m0_arvalid = 1;
    @(negedge clk);
    chk("w_first", s_wvalid, 1'b1);
    chk("w_data", {s_wdata, s_wstrb}, {64'h41, 8'h01});
    chk("aw_not_yet", s_awvalid, 1'b0);
    chk("m0_wait_w", m0_arready, 1'b0);
    step();
    m1_wvalid = 0; m1_awaddr = 32'ha000_03f8; m1_awvalid = 1;
    @(negedge clk);
    chk("aw_fwd", {s_awaddr, s_awvalid}, {32'ha000_03f8, 1'b1});
    chk("w_done_gated", s_wvalid, 1'b0);
    chk("m0_wait_aw", m0_arready, 1'b0);
    step();
    m1_awvalid = 0; s_bvalid = 1; s_bresp = RESP_SLVERR; m1_bready = 0;
    @(negedge clk);
    chk("bvalid_fwd", {m1_bvalid, m1_bresp}, {1'b1, 2'b10});
    chk("bready_held", s_bready, 1'b0);
    repeat (4) begin
      step();
      @(negedge clk);
      chk("bready_held", s_bready, 1'b0);
      chk("m0_wait_b", {m0_arready, s_arvalid}, 2'b00);
    end
    step();
    m1_bready = 1;
    @(negedge clk);
    chk("bready_rise", s_bready, 1'b1);
    step();
    s_bvalid = 0; s_bresp = '0; s_wready = 0; s_awready = 0;
    @(negedge clk);
    chk("b_done_idle", {m1_bvalid, s_arvalid}, 2'b00);
    do_read(1'b0, 32'h8000_0100, 0, 0, 64'h00ab_cdef_0000_0042, RESP_OKAY);

    // Reset one cycle after an m1 AR handshake, then a tie goes to m0.
    step();
    m1_araddr = 32'h1000_0040; m1_arvalid = 1;
    wait_arvalid("ar_timeout");
    chk("grant_addr", s_araddr, 32'h1000_0040);
    step();
    s_arready = 1;
    step();
    s_arready = 0; m1_arvalid = 0; rst = 1;
    @(negedge clk);
    chk("rst_mid_quiet", any_out(), 1'b0);
    step();
    rst = 0;
    m0_araddr = 32'h8000_0200; m0_arvalid = 1;
    m1_araddr = 32'h1000_0050; m1_arvalid = 1;
    @(negedge clk);
    chk("post_rst_quiet", any_out(), 1'b0);
    do_read(1'b0, 32'h8000_0200, 0, 0, 64'h0000_0000_0000_00aa, RESP_OKAY);
    do_read(1'b1, 32'h1000_0050, 0, 0, 64'h0000_0000_0000_00bb, RESP_OKAY);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rr_arbiter.md
Name: axi_rr_arbiter

Overview:
- Two-master to one-slave AXI4-Lite arbiter in front of the shared peripheral/memory bus (UART, memory).
- Master 0 (m0) is the IFU and issues reads only. Master 1 (m1) is the LSU and issues reads and writes.
- Exactly one transaction is outstanding at a time. Masters are served round-robin.
- Data and response fields pass through unchanged; only valid/ready are gated by the grant.

Parameters:
- ADDR_W, 32, address width of all AR/AW channels
- DATA_W, 64, R/W data width
- STRB_W, DATA_W/8, write strobe width
- RESP_W, 2, rresp/bresp width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous and active-high
- m0 AR: m0_araddr in ADDR_W; m0_arvalid in 1; m0_arready out 1
- m0 R: m0_rdata out DATA_W; m0_rresp out RESP_W; m0_rvalid out 1; m0_rready in 1
- m1 AR: m1_araddr in ADDR_W; m1_arvalid in 1; m1_arready out 1
- m1 R: m1_rdata out DATA_W; m1_rresp out RESP_W; m1_rvalid out 1; m1_rready in 1
- m1 AW: m1_awaddr in ADDR_W; m1_awvalid in 1; m1_awready out 1
- m1 W: m1_wdata in DATA_W; m1_wstrb in STRB_W; m1_wvalid in 1; m1_wready out 1
- m1 B: m1_bresp out RESP_W; m1_bvalid out 1; m1_bready in 1
- s AR: s_araddr out ADDR_W; s_arvalid out 1; s_arready in 1
- s R: s_rdata in DATA_W; s_rresp in RESP_W; s_rvalid in 1; s_rready out 1
- s AW: s_awaddr out ADDR_W; s_awvalid out 1; s_awready in 1
- s W: s_wdata out DATA_W; s_wstrb out STRB_W; s_wvalid out 1; s_wready in 1
- s B: s_bresp in RESP_W; s_bvalid in 1; s_bready out 1

Behaviour:
- States: IDLE, RD0, RD1, WR. All state is registered; all handshake outputs are decoded combinationally from the state.
- Per-transaction flags: ar_done (RD*), aw_done and w_done (WR). All flags clear on entry to any state.
- Requests: req0 = m0_arvalid. req1 = m1_awvalid | m1_wvalid | m1_arvalid. Within m1, a write takes precedence over a read.
- last_grant register (0 = m0, 1 = m1): updated on every grant; reset value is 1.
- IDLE:
  - Only req0 → RD0.
  - Only req1 → WR if (awvalid|wvalid), else RD1.
  - Both requesting → the master that is not last_grant wins.
  - No ready/valid is forwarded in IDLE, so grant latency is 1 cycle. The AR/AW valid reaches the slave in the cycle after the request is sampled.
- RDx:
  - s_arvalid = mx_arvalid & !ar_done; mx_arready = s_arready & !ar_done. ar_done sets on the s AR handshake.
  - s_rready = mx_rready & ar_done; mx_rvalid = s_rvalid & ar_done.
  - R handshake → IDLE.
- WR:
  - AW and W are forwarded independently, gated by !aw_done and !w_done respectively. W may precede AW.
  - B is forwarded once aw_done & w_done. B handshake → IDLE.
- Non-granted master: all ready/valid outputs are 0 and its data/resp outputs are 0.
- Slave address/data outputs mux from the granted master; they are 0 in IDLE.
- Reset values: state = IDLE, flags = 0, last_grant = 1. Every valid/ready output is 0 and every data output is 0 during and after reset.
- Boundary conditions:
  - Slave stalls (arready/awready/wready/bvalid/rvalid low) → hold state indefinitely; there is no timeout.
  - Master holds rready/bready low → s_rready/s_bready low; the slave keeps the response.
  - m0 request arriving during WR waits (m0_arready = 0) until the B handshake completes.
  - An error rresp/bresp is passed through unchanged; the arbiter never generates responses.
  - rst mid-transaction → next cycle IDLE; the pending transaction is abandoned and the slave must also be reset.
  - A request dropped before its handshake (protocol violation) keeps the grant until completion; this is not supported.

Decomposition:
- Shared defines (existing defines.v or axi_defs.v): state encodings, RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, bus-width macros.
- Sub-module rr_arb2: inputs req0, req1, last_grant; outputs gnt0, gnt1. Purely combinational, reused by the future xbar.

Test Plan:
- rst = 1 for 3 cycles with all masters requesting → every m*/s* valid and ready is 0 throughout; the first grant appears the cycle after rst falls.
- m0 read araddr = 0x8000_0000, slave arready after 1 cycle and rdata = 0x0000_0000_0000_1234 after 2 → m0_rdata = 0x1234 with m0_rvalid for one cycle; m1_rvalid stays 0.
- m0 and m1 assert arvalid in the same cycle post-reset → m0 served first, m1 next. Repeat with both requesting again → m1 first (alternation).
- m1 write awaddr = 0xa000_03f8, wdata = 0x41, wstrb = 0x01, wvalid 2 cycles before awvalid → s_wvalid forwarded first, then s_awvalid; s_bvalid is passed to m1_bvalid. m0_arvalid raised mid-write sees arready = 0 until the B handshake.
- Slave returns bvalid while m1_bready is held low for 5 cycles → s_bready = 0 and state stays WR; the B handshake occurs on the cycle bready rises; IDLE follows.
- rst pulsed 1 cycle after the AR handshake of an m1 read → next cycle all outputs 0; a subsequent simultaneous request grants m0 (last_grant = 1).
